// File: rtl/serial_magcomp.sv
// Bit-serial unsigned magnitude comparator: operands arrive LSB-first, one bit pair per
// accepted beat; registered one-hot AGB/AEB/ALB flags update with a one-cycle DONE pulse.
module serial_magcomp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic START,
  input  logic BIT_VALID,
  input  logic A_BIT,
  input  logic B_BIT,
  output logic BUSY,
  output logic DONE,
  output logic AGB,
  output logic AEB,
  output logic ALB
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [1:0] REL_EQ = 2'd0;
  localparam logic [1:0] REL_GT = 2'd1;
  localparam logic [1:0] REL_LT = 2'd2;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    rel;
  logic [1:0]    rel_next;
  logic          last;

  // A later (more significant) differing bit always overrides the running relation.
  always_comb begin
    rel_next = rel;
    if (A_BIT && !B_BIT)
      rel_next = REL_GT;
    else if (!A_BIT && B_BIT)
      rel_next = REL_LT;
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign BUSY = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rel   <= REL_EQ;
      DONE  <= 1'b0;
      AGB   <= 1'b0;
      AEB   <= 1'b1;
      ALB   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state <= SHIFT;
            cnt   <= '0;
            rel   <= REL_EQ;
          end
        end
        SHIFT: begin
          if (BIT_VALID) begin
            rel <= rel_next;
            if (last) begin
              // Counter is cleared instead of incremented so it never wraps.
              cnt   <= '0;
              state <= IDLE;
              DONE  <= 1'b1;
              AGB   <= (rel_next == REL_GT);
              AEB   <= (rel_next == REL_EQ);
              ALB   <= (rel_next == REL_LT);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magcomp.sv
// Randomized self-checking bench for serial_magcomp (WIDTH=8) against an integer-compare model.
module tb_serial_magcomp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, agb, aeb, alb;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected held flags (last completed comparison, or reset value).
  logic e_gt = 1'b0;
  logic e_eq = 1'b1;
  logic e_lt = 1'b0;

  serial_magcomp #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .START(start), .BIT_VALID(bit_valid),
    .A_BIT(a_bit), .B_BIT(b_bit), .BUSY(busy), .DONE(done),
    .AGB(agb), .AEB(aeb), .ALB(alb)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".agb"}, 32'(agb), 32'(e_gt));
    check({tag, ".aeb"}, 32'(aeb), 32'(e_eq));
    check({tag, ".alb"}, 32'(alb), 32'(e_lt));
  endtask

  // Called at a negedge with the DUT idle (or on its DONE cycle); returns on the DONE cycle.
  // Stall windows follow bits s1 and s2 (index < 7); START is held high during stalls.
  task automatic do_cmp(input logic [7:0] a, input logic [7:0] b,
                        input int s1, input int s2, input int slen, input string tag);
    int edges = 0;
    int stalls = 0;
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    @(negedge clk);
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom_range(0, 1));
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      @(negedge clk);
      edges++;
      if (i < 7) begin
        check({tag, ".done_early"}, 32'(done), 32'd0);
        check({tag, ".busy_mid"}, 32'(busy), 32'd1);
        if (i == s1 || i == s2) begin
          for (int k = 0; k < slen; k++) begin
            start = 1'b1; bit_valid = 1'b0;
            a_bit = 1'($urandom_range(0, 1)); b_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            edges++; stalls++;
            check({tag, ".stall_busy"}, 32'(busy), 32'd1);
            check({tag, ".stall_done"}, 32'(done), 32'd0);
          end
        end
      end
    end
    e_gt = (a > b); e_eq = (a == b); e_lt = (a < b);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".latency"}, 32'(edges), 32'(8 + stalls));
    check_flags(tag);
  endtask

  task automatic idle_cycle(input string tag);
    start = 1'b0; bit_valid = 1'b1;
    a_bit = 1'($urandom_range(0, 1)); b_bit = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, ".idle_done"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check_flags({tag, ".hold"});
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    e_gt = 1'b0; e_eq = 1'b1; e_lt = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check_flags(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    int s1, s2, slen;

    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_flags("rst");
    rst = 1'b0;
    @(negedge clk);

    do_cmp(8'hA5, 8'hA5, -1, -1, 0, "eq");
    idle_cycle("eq");

    do_cmp(8'h80, 8'h7F, -1, -1, 0, "msb_gt");
    idle_cycle("msb_gt");
    async_reset("arst");

    do_cmp(8'h7F, 8'h80, -1, -1, 0, "msb_lt");
    // START on the DONE cycle: back-to-back comparison
    do_cmp(8'h3C, 8'h3D, 2, 5, 3, "stall");
    idle_cycle("stall");

    // Abort: 4 bits of FF vs 00, then asynchronous reset mid-comparison
    start = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      start = 1'b0; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      @(negedge clk);
    end
    check("abort.busy_pre", 32'(busy), 32'd1);
    async_reset("abort");
    do_cmp(8'h00, 8'h00, -1, -1, 0, "after_abort");
    idle_cycle("after_abort");

    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      s1 = $urandom_range(0, 9);
      s2 = $urandom_range(0, 9);
      slen = $urandom_range(0, 2);
      do_cmp(ra, rb, s1, s2, slen, "rand");
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end
    idle_cycle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
